// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: EX-stage writer side of the branch predictor.
// Ports: CLK/RST; ex_* resolved branch + fetch-time prediction in;
//   flush/redirect_pc, btb_* write port, branch/mispredict counters out.
module branch_resolve_unit #(
   parameter int unsigned IDX_W      = 2,
   parameter int unsigned TAG_W      = 28,
   parameter int unsigned CNT_W      = 32,
   parameter logic [1:0]  INIT_STATE = 2'b10
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ex_valid,
   input  logic             stall,
   input  logic [31:0]      ex_pc,
   input  logic             ex_taken,
   input  logic [31:0]      ex_target,
   input  logic             ex_pred_hit,
   input  logic [31:0]      ex_pred_pc,
   input  logic [1:0]       ex_pred_state,
   output logic             flush,
   output logic [31:0]      redirect_pc,
   output logic             btb_wen,
   output logic [IDX_W-1:0] btb_idx,
   output logic [TAG_W-1:0] btb_tag,
   output logic [31:0]      btb_value,
   output logic [1:0]       btb_state,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispredict_cnt
);

   logic        accept;
   logic        pred_taken;
   logic        mispredict;
   logic        wr;
   logic [1:0]  nxt_state;
   logic [31:0] nxt_value;
   logic [31:0] nxt_redirect;

   // A branch in EX while flush is high is on the wrong path.
   assign accept     = ex_valid && !stall && !flush;
   assign pred_taken = ex_pred_hit && ex_pred_state[1];
   assign mispredict = (pred_taken != ex_taken) ||
                       (pred_taken && ex_taken &&
                        (ex_pred_pc != ex_target));

   // Misses that fall through are never allocated.
   assign wr = ex_pred_hit || ex_taken;

   assign nxt_redirect = ex_taken ? ex_target : ex_pc + 32'd4;

   always_comb begin
      nxt_state = INIT_STATE;
      nxt_value = ex_target;
      unique case (1'b1)
         (ex_pred_hit && ex_taken): begin
            nxt_state = (ex_pred_state == 2'b11) ?
                        2'b11 : ex_pred_state + 2'd1;
            nxt_value = ex_target;
         end
         (ex_pred_hit && !ex_taken): begin
            nxt_state = (ex_pred_state == 2'b00) ?
                        2'b00 : ex_pred_state - 2'd1;
            nxt_value = ex_pred_pc;
         end
         (!ex_pred_hit): begin
            nxt_state = INIT_STATE;
            nxt_value = ex_target;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         flush          <= 1'b0;
         redirect_pc    <= '0;
         btb_wen        <= 1'b0;
         btb_idx        <= '0;
         btb_tag        <= '0;
         btb_value      <= '0;
         btb_state      <= '0;
         branch_cnt     <= '0;
         mispredict_cnt <= '0;
      end else begin
         flush   <= accept && mispredict;
         btb_wen <= accept && wr;
         if (accept) begin
            branch_cnt <= branch_cnt + 1'b1;
         end
         if (accept && mispredict) begin
            redirect_pc    <= nxt_redirect;
            mispredict_cnt <= mispredict_cnt + 1'b1;
         end
         if (accept && wr) begin
            btb_idx   <= ex_pc[IDX_W+1:2];
            btb_tag   <= ex_pc[31:IDX_W+2];
            btb_value <= nxt_value;
            btb_state <= nxt_state;
         end
      end
   end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Update/writer side of the branch predictor; sits at the EX stage.
- Compares each resolved conditional branch against the prediction carried down from fetch (bp_pc, btb_hit, counter state).
- Issues a registered flush/redirect on misprediction and drives a write port into the BTB: idx, tag, value, plus 2-bit saturating state.
- Keeps branch and mispredict performance counters.

Parameters:
IDX_W, 2, BTB index width; index = pc[IDX_W+1:2]
TAG_W, 28, tag width; tag = pc[31:IDX_W+2]
CNT_W, 32, width of performance counters
INIT_STATE, 2'b10, counter state written on allocation (weakly taken)

Ports:
CLK  in  1  clock
RST  in  1  asynchronous reset, active-high
ex_valid  in  1  EX holds a valid conditional branch (beq/bne)
stall  in  1  pipeline stall; EX contents not accepted while high
ex_pc  in  32  PC of the branch (word_t)
ex_taken  in  1  actual branch outcome
ex_target  in  32  actual taken target
ex_pred_hit  in  1  btb_hit captured at fetch
ex_pred_pc  in  32  bp_pc captured at fetch
ex_pred_state  in  2  counter state read at fetch (don't-care if !ex_pred_hit)
flush  out  1  one-cycle pulse: squash IF/ID and redirect
redirect_pc  out  32  correct next PC, valid while flush=1
btb_wen  out  1  one-cycle BTB write strobe
btb_idx  out  IDX_W  write index
btb_tag  out  TAG_W  write tag
btb_value  out  32  write predicted target
btb_state  out  2  write counter state (00 SNT, 01 WNT, 10 WT, 11 ST)
branch_cnt  out  CNT_W  accepted branches
mispredict_cnt  out  CNT_W  mispredicted branches

Behaviour:
- Reset (async, RST=1): all outputs 0, including flush, btb_wen, redirect_pc, btb_* fields and both counters.
- Accept: accept = ex_valid && !stall && !flush. A branch in EX while flush=1 is wrong-path and is ignored: no write, no count.
- Latency: all outputs are registered, one cycle after accept. flush and btb_wen are single-cycle pulses, deasserted on the next edge unless a new accept occurs. Stall does not extend a pulse.
- Prediction: pred_taken = ex_pred_hit && ex_pred_state[1].
- Mispredict when either holds:
  - pred_taken != ex_taken, or
  - pred_taken && ex_taken && ex_pred_pc != ex_target.
- On mispredict: flush=1; redirect_pc = ex_taken ? ex_target : ex_pc+4 (mod 2^32; pc 0xFFFFFFFC wraps to 0).
- BTB update rules:
  - Hit, taken: state = min(state+1, 11); value = ex_target; btb_wen=1.
  - Hit, not-taken: state = max(state-1, 00); value = ex_pred_pc (unchanged); btb_wen=1.
  - Miss, taken: allocate, overwriting the resident entry at idx; state = INIT_STATE; value = ex_target; btb_wen=1.
  - Miss, not-taken: no write (btb_wen=0).
- Write fields: btb_idx/btb_tag always come from ex_pc.
- Counters: branch_cnt += 1 per accept; mispredict_cnt += 1 per mispredict; both wrap modulo 2^CNT_W to 0.
- Flush and write coincide: flush and btb_wen may pulse in the same cycle. The BTB write takes priority over any same-cycle fetch lookup; forwarding is the BTB's concern.
- Reset mid-operation: pending pulses are dropped. No partial write may be issued after RST deasserts.

Test Plan:
- Reset: RST=1 with ex_valid=1, then release -> all outputs 0; the first accept appears exactly one cycle later.
- Cold taken branch: ex_pc=0x00000044, hit=0, taken=1, target=0x00000100 -> next cycle: flush=1, redirect_pc=0x100, btb_wen=1, idx=01, tag=0x0000004, value=0x100, state=10; both counters = 1.
- Saturation: hit, state=11, taken, pred_pc=target -> no flush, btb_state=11. Hit, state=00, not-taken -> no flush, btb_state=00.
- Wrong target: hit, state=10, taken, pred_pc=0x200, target=0x300 -> flush=1, redirect_pc=0x300, btb_value=0x300, state=11.
- Not-taken mispredict at pc=0xFFFFFFFC: hit, state=10, taken=0 -> redirect_pc=0x00000000, btb_state=01.
- Squash/stall: accept causing flush while the next EX branch is valid -> the second branch is ignored (branch_cnt +1 only). stall=1 with ex_valid=1 -> no pulses, no counts. Preset mispredict_cnt=0xFFFFFFFF and mispredict once -> 0.
